// File: rtl/iterative_mul_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Holds the operation codes, the FSM state encoding and the counter-width helper.
package iterative_mul_div_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } mdu_state_e;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int get_min_width(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/iterative_mul_div_step.sv
// One combinational iteration: shift-add for multiply (LSB first) or restoring
// subtract for divide (MSB first) on a 2*BitWidth accumulator.
module iterative_mul_div_step #(
    parameter int BitWidth = 32
) (
    input  logic                    is_div,
    input  logic [2*BitWidth-1:0]   acc_in,
    input  logic [BitWidth-1:0]     operand,
    output logic [2*BitWidth-1:0]   acc_out
);

    logic [BitWidth:0]   partial;
    logic [BitWidth-1:0] trial;
    logic                fits;

    // The divide remainder is always below the divisor, so the low BitWidth
    // bits of the trial subtraction are exact whenever it fits.
    always_comb begin
        partial = '0;
        trial   = '0;
        fits    = 1'b0;
        acc_out = acc_in;
        if (is_div) begin
            partial = acc_in[2*BitWidth-1:BitWidth-1];
            trial   = partial[BitWidth-1:0] - operand;
            fits    = partial >= {1'b0, operand};
            acc_out = {(fits ? trial : partial[BitWidth-1:0]), acc_in[BitWidth-2:0], fits};
        end else begin
            partial = {1'b0, acc_in[2*BitWidth-1:BitWidth]}
                    + (acc_in[0] ? {1'b0, operand} : {(BitWidth+1){1'b0}});
            acc_out = {partial, acc_in[BitWidth-1:1]};
        end
    end

endmodule

// File: rtl/iterative_mul_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operates on magnitudes for N = BitWidth/BitsPerCycle cycles, then applies signs in FIXUP.
module iterative_mul_div
    import iterative_mul_div_pkg::*;
#(
    parameter int BitWidth     = 32,
    parameter int BitsPerCycle = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  mdu_code_e           control,
    input  logic [BitWidth-1:0] a,
    input  logic [BitWidth-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [BitWidth-1:0] hi,
    output logic [BitWidth-1:0] lo,
    output logic                div_zero
);

    localparam int Steps      = BitWidth / BitsPerCycle;
    localparam int CountWidth = get_min_width(Steps);

    mdu_state_e state, state_next;

    logic [CountWidth-1:0]  count;
    logic [2*BitWidth-1:0]  acc;
    logic [BitWidth-1:0]    operand;
    logic                   op_div, neg_quo, neg_rem, b_zero;

    logic                   is_muldiv, is_div, is_signed, sign_a, sign_b;
    logic [BitWidth-1:0]    mag_a, mag_b, quo, rem, quo_fixed, rem_fixed;
    logic [2*BitWidth-1:0]  prod_fixed;
    logic [2*BitWidth-1:0]  chain [BitsPerCycle+1];

    always_comb begin
        is_div    = (control == MDU_DIV) || (control == MDU_DIVU);
        is_muldiv = is_div || (control == MDU_MULT) || (control == MDU_MULTU);
        is_signed = (control == MDU_MULT) || (control == MDU_DIV);
        sign_a    = is_signed & a[BitWidth-1];
        sign_b    = is_signed & b[BitWidth-1];
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;
    end

    assign chain[0] = acc;
    for (genvar i = 0; i < BitsPerCycle; i++) begin : g_step
        iterative_mul_div_step #(.BitWidth(BitWidth)) u_step (
            .is_div  (op_div),
            .acc_in  (chain[i]),
            .operand (operand),
            .acc_out (chain[i+1])
        );
    end

    // A zero divisor forces the all-ones quotient regardless of signs.
    always_comb begin
        quo        = acc[BitWidth-1:0];
        rem        = acc[2*BitWidth-1:BitWidth];
        quo_fixed  = b_zero ? '1 : (neg_quo ? -quo : quo);
        rem_fixed  = neg_rem ? -rem : rem;
        prod_fixed = neg_quo ? -acc : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start && is_muldiv) state_next = ST_CALC;
            ST_CALC:  if (count == '0) state_next = ST_FIXUP;
            ST_FIXUP: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            operand  <= '0;
            op_div   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_muldiv) begin
                        op_div  <= is_div;
                        neg_quo <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        b_zero  <= (b == '0);
                        count   <= CountWidth'(Steps - 1);
                        acc     <= {{BitWidth{1'b0}}, (is_div ? mag_a : mag_b)};
                        operand <= is_div ? mag_b : mag_a;
                    end else if (start && control == MDU_MTHI) begin
                        hi <= a;
                    end else if (start && control == MDU_MTLO) begin
                        lo <= a;
                    end
                end
                ST_CALC: begin
                    acc   <= chain[BitsPerCycle];
                    count <= count - CountWidth'(1);
                end
                ST_FIXUP: begin
                    done     <= 1'b1;
                    div_zero <= op_div & b_zero;
                    if (op_div) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        {hi, lo} <= prod_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_mul_div.sv
// Scoreboard bench for iterative_mul_div: a 32-bit/1-bit-per-cycle instance and
// a 16-bit/4-bits-per-cycle instance checked against an arithmetic reference model.
module tb_iterative_mul_div;
    import iterative_mul_div_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        start32, busy32, done32, dz32;
    mdu_code_e   control32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start16, busy16, done16, dz16;
    mdu_code_e   control16;
    logic [15:0] a16, b16, hi16, lo16;

    exp_t        sb32[$];
    exp_t        sb16[$];
    exp_t        mon32, mon16;
    logic [31:0] model_hi32, model_lo32, old_lo;
    logic        model_dz32;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    iterative_mul_div #(.BitWidth(32), .BitsPerCycle(1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .control(control32),
        .a(a32), .b(b32), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32), .div_zero(dz32)
    );

    iterative_mul_div #(.BitWidth(16), .BitsPerCycle(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .control(control16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .hi(hi16), .lo(lo16), .div_zero(dz16)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic exp_t mduModel(input mdu_code_e code, input logic [31:0] a, input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        e.dz = 1'b0;
        p    = 64'd0;
        q    = 0;
        r    = 0;
        case (code)
            MDU_MULTU: p = ua * ub;
            MDU_MULT:  p = 64'(sa * sb);
            default: begin
                if (ub == 64'd0) begin
                    e.dz = 1'b1;
                    q    = -1;
                    r    = longint'(ua);
                end else if (code == MDU_DIVU) begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end
        endcase
        if (code == MDU_MULT || code == MDU_MULTU) begin
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
        end else begin
            e.hi = 32'(64'(r) & mask);
            e.lo = 32'(64'(q) & mask);
        end
        return e;
    endfunction

    function automatic mdu_code_e pickOp();
        case ($urandom_range(0, 3))
            0:       return MDU_MULT;
            1:       return MDU_MULTU;
            2:       return MDU_DIV;
            default: return MDU_DIVU;
        endcase
    endfunction

    // Drives one request for a single cycle; called just after a falling edge.
    task automatic applyStimulus(input bit sel, input mdu_code_e code, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (sel) begin
            start16 = 1'b1; control16 = code; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start32 = 1'b1; control32 = code; a32 = a; b32 = b;
        end
        if (code inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) begin
            e = mduModel(code, a, b, sel ? 16 : 32);
            if (sel) sb16.push_back(e);
            else begin
                sb32.push_back(e);
                model_hi32 = e.hi; model_lo32 = e.lo; model_dz32 = e.dz;
            end
        end else if (!sel && code == MDU_MTHI) model_hi32 = a;
        else if (!sel && code == MDU_MTLO) model_lo32 = a;
        @(posedge clk);
        #1;
        start16 = 1'b0; control16 = MDU_NONE;
        start32 = 1'b0; control32 = MDU_NONE;
    endtask

    // Counts rising edges until done; returns on the falling edge of the done cycle.
    task automatic waitDone(input bit sel, input int expected_cycles);
        int cycles;
        cycles = 0;
        while (!(sel ? done16 : done32) && cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        if (sel) checkOutput("latency16", 64'(cycles), 64'(expected_cycles));
        else     checkOutput("latency32", 64'(cycles), 64'(expected_cycles));
    endtask

    always @(negedge clk) begin
        if (!reset && done32) begin
            if (sb32.size() == 0) checkOutput("unexpected_done32", 64'd1, 64'd0);
            else begin
                mon32 = sb32.pop_front();
                checkOutput("hi32", 64'(hi32), 64'(mon32.hi));
                checkOutput("lo32", 64'(lo32), 64'(mon32.lo));
                checkOutput("div_zero32", 64'(dz32), 64'(mon32.dz));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done16) begin
            if (sb16.size() == 0) checkOutput("unexpected_done16", 64'd1, 64'd0);
            else begin
                mon16 = sb16.pop_front();
                checkOutput("hi16", 64'(hi16), 64'(mon16.hi));
                checkOutput("lo16", 64'(lo16), 64'(mon16.lo));
                checkOutput("div_zero16", 64'(dz16), 64'(mon16.dz));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start32 = 1'b0; control32 = MDU_NONE; a32 = '0; b32 = '0;
        start16 = 1'b0; control16 = MDU_NONE; a16 = '0; b16 = '0;
        model_hi32 = '0; model_lo32 = '0; model_dz32 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(hi32), 64'd0);
        checkOutput("reset_lo", 64'(lo32), 64'd0);
        checkOutput("reset_busy", 64'(busy32), 64'd0);
        checkOutput("reset_done", 64'(done32), 64'd0);
        checkOutput("reset_div_zero", 64'(dz32), 64'd0);
        checkOutput("reset_hi16", 64'(hi16), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Done arrives on the (N+1)th edge after the accepting edge.
        $display("[TB] directed 32-bit mul/div");
        applyStimulus(0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); waitDone(0, 33);
        applyStimulus(0, MDU_MULT,  32'hFFFFFFFD, 32'd7);        waitDone(0, 33);
        applyStimulus(0, MDU_DIVU,  32'd7,        32'd2);        waitDone(0, 33);
        applyStimulus(0, MDU_DIV,   32'hFFFFFFF9, 32'd2);        waitDone(0, 33);
        applyStimulus(0, MDU_DIVU,  32'd5,        32'd0);        waitDone(0, 33);
        applyStimulus(0, MDU_DIV,   32'h80000000, 32'hFFFFFFFF); waitDone(0, 33);

        $display("[TB] MTHI and ignored requests");
        applyStimulus(0, MDU_MTHI, 32'hA5A5A5A5, 32'd0);
        checkOutput("mthi_hi", 64'(hi32), 64'(model_hi32));
        checkOutput("mthi_lo", 64'(lo32), 64'(model_lo32));
        checkOutput("mthi_busy", 64'(busy32), 64'd0);
        checkOutput("mthi_done", 64'(done32), 64'd0);
        checkOutput("mthi_div_zero", 64'(dz32), 64'(model_dz32));
        @(negedge clk);
        old_lo = model_lo32;
        applyStimulus(0, MDU_MULTU, 32'h10, 32'h20);
        checkOutput("busy_after_start", 64'(busy32), 64'd1);
        @(negedge clk);
        start32 = 1'b1; control32 = MDU_MTLO; a32 = 32'hDEADBEEF;
        @(posedge clk); #1;
        checkOutput("mtlo_while_busy", 64'(lo32), 64'(old_lo));
        control32 = MDU_MULT; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0; control32 = MDU_NONE;
        checkOutput("busy_mid_calc", 64'(busy32), 64'd1);
        waitDone(0, 31);
        start32 = 1'b1; control32 = MDU_NONE; a32 = 32'h11111111;
        @(posedge clk); #1;
        checkOutput("none_busy", 64'(busy32), 64'd0);
        control32 = mdu_code_e'(3'd7);
        @(posedge clk); #1;
        checkOutput("undef_busy", 64'(busy32), 64'd0);
        checkOutput("undef_hi", 64'(hi32), 64'(model_hi32));
        checkOutput("undef_lo", 64'(lo32), 64'(model_lo32));
        start32 = 1'b0; control32 = MDU_NONE;
        @(negedge clk);

        $display("[TB] asynchronous reset mid-calculation");
        applyStimulus(0, MDU_MULTU, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_busy", 64'(busy32), 64'd0);
        checkOutput("async_hi", 64'(hi32), 64'd0);
        checkOutput("async_lo", 64'(lo32), 64'd0);
        sb32.delete();
        model_hi32 = '0; model_lo32 = '0; model_dz32 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, MDU_MULTU, 32'h00001234, 32'h00005678); waitDone(0, 33);

        $display("[TB] 16-bit, 4 bits per cycle");
        applyStimulus(1, MDU_MULTU, 32'h1234, 32'h0010); waitDone(1, 5);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            applyStimulus(1, pickOp(), ra, rb);
            waitDone(1, 5);
        end

        $display("[TB] random 32-bit back-to-back");
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(0, pickOp(), ra, rb);
            waitDone(0, 33);
        end

        repeat (2) @(negedge clk);
        checkOutput("sb32_empty", 64'(sb32.size()), 64'd0);
        checkOutput("sb16_empty", 64'(sb16.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
